// File: rtl/register_alias_file.sv
// rtl/register_alias_file.sv - architectural register file with ROB rename status, two dispatch read ports (optional RAF_CDB_BYPASS_EN)
//
// common_data_bus_i carries NUM_CDB_INPUTS lanes; lane l occupies
// bits [l*LANE_W +: LANE_W] and is laid out as {valid, rob_dest, data}.
// RAF_CDB_BYPASS_EN: when defined, a busy read port takes the value of the
// lowest-numbered valid CDB lane whose rob_dest matches the owning tag.

module register_alias_file #(
    parameter int WIDTH          = 32,
    parameter int NUM_REGS       = 32,
    parameter int ROB_IDX_LEN    = 4,
    parameter int NUM_CDB_INPUTS = 2
) (
    input  logic                                                    clk,
    input  logic                                                    rst,
    input  logic                                                    commit_i,
    input  logic [4:0]                                              commit_idx_i,
    input  logic [WIDTH-1:0]                                        commit_val_i,
    input  logic [ROB_IDX_LEN-1:0]                                  commit_tag_i,
    input  logic                                                    speculate_i,
    input  logic [4:0]                                              speculate_idx_i,
    input  logic [ROB_IDX_LEN-1:0]                                  speculate_val_i,
    input  logic                                                    flush_i,
    input  logic [NUM_CDB_INPUTS*(1+ROB_IDX_LEN+WIDTH)-1:0]         common_data_bus_i,
    input  logic [4:0]                                              rs1_idx_i,
    input  logic [4:0]                                              rs2_idx_i,
    output logic [WIDTH-1:0]                                        rs1_val_o,
    output logic [WIDTH-1:0]                                        rs2_val_o,
    output logic                                                    rs1_busy_o,
    output logic                                                    rs2_busy_o,
    output logic [ROB_IDX_LEN-1:0]                                  rs1_tag_o,
    output logic [ROB_IDX_LEN-1:0]                                  rs2_tag_o,
    output logic [$clog2(NUM_REGS):0]                               busy_count_o
);

    localparam int LANE_W = 1 + ROB_IDX_LEN + WIDTH;
    localparam int CNT_W  = $clog2(NUM_REGS) + 1;

    typedef struct packed {
        logic [WIDTH-1:0]       val;
        logic                   busy;
        logic [ROB_IDX_LEN-1:0] tag;
    } rd_t;

    logic [NUM_REGS-1:0][WIDTH-1:0]       val_q;
    logic [NUM_REGS-1:0]                  busy_q;
    logic [NUM_REGS-1:0]                  busy_d;
    logic [NUM_REGS-1:0][ROB_IDX_LEN-1:0] tag_q;
    logic [NUM_REGS-1:0][ROB_IDX_LEN-1:0] tag_d;
    logic [CNT_W-1:0]                     count_d;
    logic                                 commit_hit;
    logic                                 commit_release;
    logic                                 spec_hit;
    rd_t                                  rd1;
    rd_t                                  rd2;

    // x0 never takes writes; a commit only releases ownership if its tag still owns the register
    assign commit_hit     = commit_i && (commit_idx_i != 5'd0);
    assign commit_release = commit_hit && busy_q[commit_idx_i] &&
                            (tag_q[commit_idx_i] == commit_tag_i);
    assign spec_hit       = speculate_i && !flush_i && (speculate_idx_i != 5'd0);

    // Next rename state: release first, then speculate overrides, flush clears everything
    always_comb begin
        busy_d = busy_q;
        tag_d  = tag_q;
        if (commit_release) begin
            busy_d[commit_idx_i] = 1'b0;
        end
        if (spec_hit) begin
            busy_d[speculate_idx_i] = 1'b1;
            tag_d[speculate_idx_i]  = speculate_val_i;
        end
        if (flush_i) begin
            busy_d = '0;
        end
        busy_d[0] = 1'b0;
    end

    // Population count of the next busy vector so the counter moves with the busy bits
    always_comb begin
        count_d = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            count_d = count_d + CNT_W'(busy_d[r]);
        end
    end

    // Architectural state and rename status registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            val_q        <= '0;
            busy_q       <= '0;
            tag_q        <= '0;
            busy_count_o <= '0;
        end else begin
            if (commit_hit) begin
                val_q[commit_idx_i] <= commit_val_i;
            end
            busy_q       <= busy_d;
            tag_q        <= tag_d;
            busy_count_o <= count_d;
        end
    end

    // A read sees pre-speculate state, with the retiring value forwarded in the same cycle
    function automatic rd_t read_port(input logic [4:0] idx);
        rd_t r;
        r.val  = val_q[idx];
        r.busy = busy_q[idx];
        r.tag  = tag_q[idx];
        if (commit_i && (commit_idx_i == idx)) begin
            r.val = commit_val_i;
            if (r.busy && (r.tag == commit_tag_i)) begin
                r.busy = 1'b0;
            end
        end
`ifdef RAF_CDB_BYPASS_EN
        for (int l = 0; l < NUM_CDB_INPUTS; l++) begin
            logic [LANE_W-1:0] lane;
            lane = common_data_bus_i[l*LANE_W +: LANE_W];
            if (r.busy && lane[LANE_W-1] && (lane[WIDTH +: ROB_IDX_LEN] == r.tag)) begin
                r.val  = lane[WIDTH-1:0];
                r.busy = 1'b0;
            end
        end
`endif
        if (idx == 5'd0) begin
            r = '0;
        end
        return r;
    endfunction

`ifndef RAF_CDB_BYPASS_EN
    logic unused_cdb;
    assign unused_cdb = ^common_data_bus_i;
`endif

    // Both dispatch read ports
    always_comb begin
        rd1 = read_port(rs1_idx_i);
        rd2 = read_port(rs2_idx_i);
    end

    assign rs1_val_o  = rd1.val;
    assign rs1_busy_o = rd1.busy;
    assign rs1_tag_o  = rd1.tag;
    assign rs2_val_o  = rd2.val;
    assign rs2_busy_o = rd2.busy;
    assign rs2_tag_o  = rd2.tag;

endmodule

// File: tb/tb_register_alias_file.sv
// tb/tb_register_alias_file.sv - scoreboard testbench for register_alias_file

module tb_register_alias_file;

    localparam int WIDTH    = 32;
    localparam int NUM_REGS = 32;
    localparam int TAG_W    = 4;
    localparam int NCDB     = 2;
    localparam int LANE_W   = 1 + TAG_W + WIDTH;

    logic                   clk;
    logic                   rst;
    logic                   commit_i;
    logic [4:0]             commit_idx_i;
    logic [WIDTH-1:0]       commit_val_i;
    logic [TAG_W-1:0]       commit_tag_i;
    logic                   speculate_i;
    logic [4:0]             speculate_idx_i;
    logic [TAG_W-1:0]       speculate_val_i;
    logic                   flush_i;
    logic [NCDB*LANE_W-1:0] common_data_bus_i;
    logic [4:0]             rs1_idx_i;
    logic [4:0]             rs2_idx_i;
    logic [WIDTH-1:0]       rs1_val_o;
    logic [WIDTH-1:0]       rs2_val_o;
    logic                   rs1_busy_o;
    logic                   rs2_busy_o;
    logic [TAG_W-1:0]       rs1_tag_o;
    logic [TAG_W-1:0]       rs2_tag_o;
    logic [5:0]             busy_count_o;

    register_alias_file #(
        .WIDTH(WIDTH), .NUM_REGS(NUM_REGS), .ROB_IDX_LEN(TAG_W), .NUM_CDB_INPUTS(NCDB)
    ) dut (
        .clk(clk), .rst(rst),
        .commit_i(commit_i), .commit_idx_i(commit_idx_i),
        .commit_val_i(commit_val_i), .commit_tag_i(commit_tag_i),
        .speculate_i(speculate_i), .speculate_idx_i(speculate_idx_i),
        .speculate_val_i(speculate_val_i), .flush_i(flush_i),
        .common_data_bus_i(common_data_bus_i),
        .rs1_idx_i(rs1_idx_i), .rs2_idx_i(rs2_idx_i),
        .rs1_val_o(rs1_val_o), .rs2_val_o(rs2_val_o),
        .rs1_busy_o(rs1_busy_o), .rs2_busy_o(rs2_busy_o),
        .rs1_tag_o(rs1_tag_o), .rs2_tag_o(rs2_tag_o),
        .busy_count_o(busy_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [WIDTH-1:0] val;
        logic             busy;
        logic [TAG_W-1:0] tag;
    } rd_t;

    typedef struct {
        rd_t        r1;
        rd_t        r2;
        logic [5:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    logic [WIDTH-1:0] m_val  [NUM_REGS];
    logic             m_busy [NUM_REGS];
    logic [TAG_W-1:0] m_tag  [NUM_REGS];
    logic [5:0]       m_count;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [LANE_W-1:0] lane(input logic v, input logic [TAG_W-1:0] d,
                                               input logic [WIDTH-1:0] data);
        return {v, d, data};
    endfunction

    task automatic model_reset();
        for (int r = 0; r < NUM_REGS; r++) begin
            m_val[r]  = '0;
            m_busy[r] = 1'b0;
            m_tag[r]  = '0;
        end
        m_count = '0;
    endtask

    function automatic rd_t model_read(input logic [4:0] idx);
        rd_t r;
        r.val  = m_val[idx];
        r.busy = m_busy[idx];
        r.tag  = m_tag[idx];
        if (idx == 5'd0) return '0;
        if (commit_i && commit_idx_i == idx) begin
            r.val = commit_val_i;
            if (r.busy && r.tag == commit_tag_i) r.busy = 1'b0;
        end
`ifdef RAF_CDB_BYPASS_EN
        if (r.busy) begin
            for (int l = NCDB - 1; l >= 0; l--) begin
                logic [LANE_W-1:0] ln;
                ln = common_data_bus_i[l*LANE_W +: LANE_W];
                if (ln[LANE_W-1] && ln[WIDTH +: TAG_W] == r.tag) begin
                    r.val  = ln[WIDTH-1:0];
                    r.busy = 1'b0;
                end
            end
        end
`endif
        return r;
    endfunction

    task automatic model_update();
        if (commit_i && commit_idx_i != 5'd0) begin
            m_val[commit_idx_i] = commit_val_i;
            if (m_busy[commit_idx_i] && m_tag[commit_idx_i] == commit_tag_i)
                m_busy[commit_idx_i] = 1'b0;
        end
        if (speculate_i && !flush_i && speculate_idx_i != 5'd0) begin
            m_busy[speculate_idx_i] = 1'b1;
            m_tag[speculate_idx_i]  = speculate_val_i;
        end
        if (flush_i) begin
            for (int r = 0; r < NUM_REGS; r++) m_busy[r] = 1'b0;
        end
        m_count = '0;
        for (int r = 1; r < NUM_REGS; r++) m_count = m_count + 6'(m_busy[r]);
    endtask

    task automatic push_expect();
        exp_t e;
        e.r1  = model_read(rs1_idx_i);
        e.r2  = model_read(rs2_idx_i);
        e.cnt = m_count;
        exp_q.push_back(e);
    endtask

    task automatic pop_compare();
        exp_t e;
        check("sb_depth", 64'(exp_q.size()), 64'd1);
        e = exp_q.pop_front();
        check("rs1_val",  64'(rs1_val_o),  64'(e.r1.val));
        check("rs1_busy", 64'(rs1_busy_o), 64'(e.r1.busy));
        check("rs1_tag",  64'(rs1_tag_o),  64'(e.r1.tag));
        check("rs2_val",  64'(rs2_val_o),  64'(e.r2.val));
        check("rs2_busy", 64'(rs2_busy_o), 64'(e.r2.busy));
        check("rs2_tag",  64'(rs2_tag_o),  64'(e.r2.tag));
        check("busy_cnt", 64'(busy_count_o), 64'(e.cnt));
    endtask

    // One cycle: drive, record expectation, compare at negedge, advance model at posedge
    task automatic step(input logic c, input logic [4:0] ci, input logic [WIDTH-1:0] cv,
                        input logic [TAG_W-1:0] ct, input logic s, input logic [4:0] si,
                        input logic [TAG_W-1:0] sv, input logic f,
                        input logic [4:0] r1, input logic [4:0] r2);
        commit_i        = c;
        commit_idx_i    = ci;
        commit_val_i    = cv;
        commit_tag_i    = ct;
        speculate_i     = s;
        speculate_idx_i = si;
        speculate_val_i = sv;
        flush_i         = f;
        rs1_idx_i       = r1;
        rs2_idx_i       = r2;
        push_expect();
        @(negedge clk);
        pop_compare();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic read_only(input logic [4:0] r1, input logic [4:0] r2);
        step(1'b0, 5'd0, '0, '0, 1'b0, 5'd0, '0, 1'b0, r1, r2);
    endtask

    task automatic async_reset();
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        push_expect();
        pop_compare();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        commit_i = 0; commit_idx_i = 0; commit_val_i = 0; commit_tag_i = 0;
        speculate_i = 0; speculate_idx_i = 0; speculate_val_i = 0; flush_i = 0;
        common_data_bus_i = '0; rs1_idx_i = 0; rs2_idx_i = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        // reset state
        read_only(5'd5, 5'd0);

        // rename then commit
        step(0, 0, 0, 0, 1, 5'd5, 4'd3, 0, 5'd5, 5'd5);
        read_only(5'd5, 5'd1);
        step(1, 5'd5, 32'hDEADBEEF, 4'd3, 0, 0, 0, 0, 5'd5, 5'd5);
        read_only(5'd5, 5'd0);

        // stale commit
        step(0, 0, 0, 0, 1, 5'd7, 4'd2, 0, 5'd7, 5'd0);
        step(0, 0, 0, 0, 1, 5'd7, 4'd4, 0, 5'd7, 5'd0);
        step(1, 5'd7, 32'h11, 4'd2, 0, 0, 0, 0, 5'd7, 5'd7);
        read_only(5'd7, 5'd0);
        step(1, 5'd7, 32'h22, 4'd4, 0, 0, 0, 0, 5'd7, 5'd0);
        read_only(5'd7, 5'd0);

        // same-cycle commit/speculate collision
        step(1, 5'd9, 32'h55, 4'd1, 1, 5'd9, 4'd6, 0, 5'd9, 5'd9);
        read_only(5'd9, 5'd0);

        // flush with simultaneous speculate and commit
        step(0, 0, 0, 0, 1, 5'd3, 4'd1, 0, 5'd3, 5'd4);
        step(0, 0, 0, 0, 1, 5'd4, 4'd2, 0, 5'd3, 5'd4);
        step(0, 0, 0, 0, 1, 5'd8, 4'd3, 0, 5'd8, 5'd9);
        step(1, 5'd3, 32'h9, 4'd7, 1, 5'd10, 4'd5, 1, 5'd3, 5'd10);
        read_only(5'd3, 5'd10);

        // x0 is hardwired
        step(1, 5'd0, 32'hABC, 4'd0, 1, 5'd0, 4'd7, 0, 5'd0, 5'd0);
        read_only(5'd0, 5'd0);

        // CDB snoop at dispatch: lane 1 only, then both lanes matching
        step(0, 0, 0, 0, 1, 5'd6, 4'd2, 0, 5'd6, 5'd6);
        common_data_bus_i = {lane(1'b1, 4'd2, 32'h77), lane(1'b1, 4'd9, 32'h99)};
        read_only(5'd0, 5'd6);
        common_data_bus_i = {lane(1'b1, 4'd2, 32'h77), lane(1'b1, 4'd2, 32'h66)};
        read_only(5'd6, 5'd6);
        common_data_bus_i = {lane(1'b0, 4'd2, 32'h77), lane(1'b0, 4'd2, 32'h66)};
        read_only(5'd6, 5'd0);
        common_data_bus_i = '0;

        // asynchronous reset mid-cycle with pending ownership
        step(0, 0, 0, 0, 1, 5'd5, 4'd3, 0, 5'd5, 5'd6);
        async_reset();
        read_only(5'd5, 5'd6);

        // randomized traffic on a small register window
        for (int i = 0; i < 80; i++) begin
            logic [4:0]       ci;
            logic [TAG_W-1:0] ct;
            ci = 5'($urandom_range(0, 7));
            ct = ($urandom_range(0, 1) == 1) ? m_tag[ci] : 4'($urandom_range(0, 15));
            common_data_bus_i = {lane(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom),
                                 lane(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom)};
            step(1'($urandom_range(0, 1)), ci, $urandom, ct,
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 15) == 0),
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
